// File: rtl/mem_access_unit.sv
// Memory-stage access controller.
// Takes the effective address and store data from the datapath and runs one
// load/store on a wait-stated word bus. It returns formatted load data and
// holds the CPU with stall until the access retires.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Halfwords need addr[0]=0; words (and size 11) need addr[1:0]=00
    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lo);
        logic ok;
        case (sz)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

    // Little-endian byte enables for the addressed lane(s)
    function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across every lane so the enabled lane carries it
    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of the bus word and extend to 32 bits
    function automatic logic [31:0] format_load(input logic [1:0] sz, input logic [1:0] lo,
                                                input logic sx, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              sext_q, sext_d;
    logic              wr_q, wr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       baddr_q, baddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       bwd_q, bwd_d;
    logic              access_s;

    assign access_s = req_valid & (mem_read | mem_write);

    // CPU is held while an access is pending and not yet retiring; reset releases it at once
    assign stall = access_s & ~rst & (state_q != ST_DONE) & (state_q != ST_ERR);

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        lane_d  = lane_q;
        sext_d  = sext_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        baddr_d = baddr_q;
        be_d    = be_q;
        bwd_d   = bwd_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    if (is_aligned(size, addr[1:0])) begin
                        state_d = ST_BUSY;
                        size_d  = size;
                        lane_d  = addr[1:0];
                        sext_d  = sign_ext;
                        wr_d    = mem_write;
                        cnt_d   = {CNT_W{1'b0}};
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        baddr_d = {addr[31:2], 2'b00};
                        be_d    = byte_enables(size, addr[1:0]);
                        bwd_d   = lane_wdata(size, wdata);
                    end else begin
                        state_d = ST_ERR;
                        mis_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!wr_q) begin
                        rdata_d = format_load(size_q, lane_q, sext_q, bus_rdata);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!wr_q) begin
                        rdata_d = 32'h0000_0000;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            sext_q  <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0000_0000;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            baddr_q <= 32'h0000_0000;
            be_q    <= 4'b0000;
            bwd_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            sext_q  <= sext_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            baddr_q <= baddr_d;
            be_q    <= be_d;
            bwd_q   <= bwd_d;
        end
    end

    assign rdata        = rdata_q;
    assign done         = done_q;
    assign misalign_exc = mis_q;
    assign bus_err      = err_q;
    assign bus_req      = req_q;
    assign bus_we       = we_q;
    assign bus_addr     = baddr_q;
    assign bus_be       = be_q;
    assign bus_wdata    = bwd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// Each access pushes its expected retirement record into a scoreboard queue.
// The record is popped and checked when done or misalign_exc fires.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misalign_exc;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .size         (size),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .done         (done),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one access at a negedge and follow it cycle by cycle until it retires.
    // ack_delay = number of BUSY cycles without ack (-1 = never ack).
    task automatic run_access(input string name, input logic wr, input logic [1:0] sz,
                              input logic sx, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rword, input int ack_delay,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_rd, input logic exp_err,
                              input logic exp_mis, input int exp_stall, input int exp_req);
        int   stall_cnt;
        int   req_cnt;
        bit   fin;
        exp_t e;
        exp_t got;
        stall_cnt = 0;
        req_cnt   = 0;
        fin       = 1'b0;
        req_valid = 1'b1;
        mem_read  = ~wr;
        mem_write = wr;
        size      = sz;
        sign_ext  = sx;
        addr      = a;
        wdata     = wd;
        bus_rdata = rword;
        bus_ack   = 1'b0;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.mis   = exp_mis;
        sb_q.push_back(e);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            #1;
            if (stall) stall_cnt++;
            if (done || misalign_exc) begin
                if (sb_q.size() == 0) begin
                    check({name, " scoreboard_empty"}, 32'd1, 32'd0);
                end else begin
                    got = sb_q.pop_front();
                    check({name, " rdata"}, rdata, got.rdata);
                    check({name, " bus_err"}, {31'd0, bus_err}, {31'd0, got.err});
                    check({name, " misalign_exc"}, {31'd0, misalign_exc}, {31'd0, got.mis});
                    check({name, " done"}, {31'd0, done}, {31'd0, ~got.mis});
                end
                check({name, " bus_req_dropped"}, {31'd0, bus_req}, 32'd0);
                fin = 1'b1;
            end
            if (bus_req) begin
                check({name, " bus_we"}, {31'd0, bus_we}, {31'd0, wr});
                check({name, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
                check({name, " bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
                if (wr) check({name, " bus_wdata"}, bus_wdata, exp_wd);
                bus_ack = (req_cnt == ack_delay);
                req_cnt++;
            end else begin
                bus_ack = 1'b0;
            end
            if (fin) begin
                req_valid = 1'b0;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                bus_ack   = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!fin) begin
            check({name, " retire_within_budget"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            bus_ack   = 1'b0;
        end
        check({name, " stall_cycles"}, stall_cnt, exp_stall);
        check({name, " bus_req_cycles"}, req_cnt, exp_req);
        @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        size      = 2'b00;
        sign_ext  = 1'b0;
        addr      = 32'h0000_0000;
        wdata     = 32'h0000_0000;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0000_0000;
        repeat (2) @(negedge clk);

        check("rst rdata", rdata, 32'h0);
        check("rst bus_req", {31'd0, bus_req}, 32'd0);
        check("rst bus_we", {31'd0, bus_we}, 32'd0);
        check("rst bus_addr", bus_addr, 32'h0);
        check("rst bus_be", {28'd0, bus_be}, 32'd0);
        check("rst bus_wdata", bus_wdata, 32'h0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst misalign_exc", {31'd0, misalign_exc}, 32'd0);
        check("rst bus_err", {31'd0, bus_err}, 32'd0);
        check("rst stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //          name         wr    sz     sx    addr          wdata         bus_rdata     ack be      exp_wdata     exp_rdata     err   mis   stall req
        run_access("lw",        1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1);
        run_access("lb_signed", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 2, 1);
        run_access("lbu",       1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 2, 1);
        run_access("lh_signed", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 3, 2);
        run_access("sb_lane1",  1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00A5, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001, 1'b0, 1'b0, 3, 2);
        run_access("sh_wait3",  1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 32'h0,        3, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_8001, 1'b0, 1'b0, 5, 4);
        run_access("lw_misal",  1'b0, 2'b10, 1'b0, 32'h0000_4001, 32'h0,        32'h1111_1111, 0, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b1, 1, 0);
        run_access("sh_misal",  1'b1, 2'b01, 1'b0, 32'h0000_4005, 32'h0000_1234, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b1, 1, 0);
        run_access("lw_timeout",1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0,        32'h7777_7777, -1, 4'b1111, 32'h0,       32'h0000_0000, 1'b1, 1'b0, 5, 4);
        run_access("lw_after",  1'b0, 2'b11, 1'b0, 32'h0000_6008, 32'h0,        32'h0BAD_F00D, 0, 4'b1111, 32'h0,        32'h0BAD_F00D, 1'b0, 1'b0, 2, 1);

        // Reset in the middle of a store: outputs clear without a clock edge
        req_valid = 1'b1;
        mem_write = 1'b1;
        mem_read  = 1'b0;
        size      = 2'b10;
        addr      = 32'h0000_7000;
        wdata     = 32'h1122_3344;
        bus_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst bus_req_before", {31'd0, bus_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst bus_req", {31'd0, bus_req}, 32'd0);
        check("midrst bus_we", {31'd0, bus_we}, 32'd0);
        check("midrst bus_be", {28'd0, bus_be}, 32'd0);
        check("midrst stall", {31'd0, stall}, 32'd0);
        check("midrst rdata", rdata, 32'h0);
        req_valid = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack done", {31'd0, done}, 32'd0);
            check("late_ack bus_err", {31'd0, bus_err}, 32'd0);
        end
        bus_ack = 1'b0;
        check("scoreboard drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage controller directly downstream of the CPU datapath.
- Takes the ALU result as the effective address and register B as store data, and runs one load/store transaction on a wait-stated word bus.
- Formats the load result (byte/half/word, sign/zero extension) into the datapath's Data_in.
- Holds the CPU with `stall` until the access retires, and flags misalignment and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without bus_ack before the access is aborted with bus_err.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU presents a memory instruction this cycle
- mem_read  in  1  load
- mem_write  in  1  store (wins if both mem_read and mem_write are set; the read is ignored)
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend
- addr  in  32  effective address (ALU_out)
- wdata  in  32  store data (Data_out)
- rdata  out  32  formatted load data to the datapath (Data_in)
- stall  out  1  CPU must hold PC and pipeline this cycle
- done  out  1  one-cycle pulse: access retired
- misalign_exc  out  1  one-cycle pulse: misaligned access rejected
- bus_err  out  1  one-cycle pulse, coincident with done: timeout abort
- bus_req  out  1  bus request, registered
- bus_we  out  1  write strobe, registered
- bus_addr  out  32  {addr[31:2],2'b00}, registered
- bus_be  out  4  byte enables, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_ack  in  1  bus completes the transfer this cycle
- bus_rdata  in  32  read word, valid when bus_ack=1

Behaviour:
- Reset (async, effective immediately, also mid-transaction): state=IDLE. All registered outputs are 0 (rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata, done, misalign_exc, bus_err). Timeout counter is 0. A pending transaction is abandoned; a late bus_ack is ignored.
- FSM states: IDLE, BUSY, DONE, ERR.
- An access is requested when req_valid & (mem_read|mem_write).
- Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=00.
- IDLE -> BUSY on an aligned access.
  - Latch size, sign_ext, addr[1:0] and the write flag.
  - Drive bus_req=1, bus_we=write, bus_addr, bus_be and bus_wdata on the same edge.
  - Clear the counter.
- IDLE -> ERR on a misaligned access. No bus activity.
- BUSY -> DONE on bus_ack.
  - Loads register the formatted rdata.
  - Drop bus_req/bus_we on that edge.
- BUSY -> DONE on timeout, when the counter reaches TIMEOUT_CYCLES-1 with no ack.
  - Drop bus_req.
  - rdata=0.
  - bus_err pulses together with done.
- BUSY, otherwise: counter += 1. Bus outputs are held stable.
- DONE -> IDLE unconditionally. done=1 for exactly this cycle.
- ERR -> IDLE unconditionally. misalign_exc=1 for exactly this cycle.
- stall = access requested & state∉{DONE,ERR} (combinational).
  - Minimum access latency is 2 stall cycles (IDLE issue cycle, then a BUSY cycle with immediate ack), then DONE.
  - A misaligned access costs 1 stall cycle, then ERR.
- Lanes are little-endian: lane = addr[1:0] (bytes), addr[1] (halves).
- Store byte enables:
  - byte: be = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}
  - word: be = 1111, wdata unchanged
- Load formatting: select the lane from bus_rdata, then sign- or zero-extend to 32 bits.
- rdata holds its value until the next load completes. Stores and timeouts do not update it, except that a timeout on a load sets it to 0.
- Back-to-back accesses: a new request seen in DONE is not issued until the following IDLE cycle. The CPU advances at the end of DONE, so this is safe.
- bus_ack outside BUSY is ignored.

Test Plan:
- Word load, addr=0x0000_1004, bus_ack on the first BUSY cycle, bus_rdata=0xDEAD_BEEF -> bus_addr=0x1004, be=1111, bus_we=0, stall high for 2 cycles, done pulse, rdata=0xDEAD_BEEF.
- Signed byte load, addr=0x...03, bus_rdata=0x80_12_34_56, sign_ext=1 -> rdata=0xFFFF_FF80. Repeat with sign_ext=0 -> rdata=0x0000_0080.
- Halfword store, addr=0x...02, wdata=0x0000_ABCD, ack after 3 wait cycles -> bus_we=1, be=1100, bus_wdata=0xABCD_ABCD held stable for all BUSY cycles, stall high for 5 cycles, done pulse.
- Misaligned word load, addr=0x...01 -> bus_req never asserted, stall high for 1 cycle, misalign_exc pulse, state back to IDLE.
- Timeout with TIMEOUT_CYCLES=4 and no bus_ack -> bus_req high for exactly 4 cycles, then done and bus_err pulse together, rdata=0.
- rst asserted during BUSY mid-store -> bus_req, bus_we, bus_be and stall go to 0 without waiting for a clock edge. A bus_ack arriving after rst deasserts produces no done.
